line_draw_ctrl: RTL and testbench

//  Sequential line rasteriser sitting between the GPU command decoder and the

---
 rtl/line_draw_ctrl.sv | 157 +++++++++++++++
 tb/tb_line_draw_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_draw_ctrl.sv
// Bresenham line rasteriser: latches one (x1,y1)->(x2,y2) command and
// streams every pixel of the line over a valid/ready handshake.
module line_draw_ctrl #(
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic               abort,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               done
);

    localparam int EW = COORD_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0] x2_q, x2_d, y2_q, y2_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    logic signed [EW-1:0] adx, ady, err_n;
    logic signed [EW:0] e2, dx_ext, dy_ext;
    logic step_x, step_y, at_end;

    // e2 carries one extra bit so doubling err can never wrap
    always_comb begin
        e2     = {err_q, 1'b0};
        dx_ext = {dx_q[EW-1], dx_q};
        dy_ext = {dy_q[EW-1], dy_q};
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);
        at_end = (cur_x_q == x2_q) && (cur_y_q == y2_q);
    end

    always_comb begin
        state_d  = state_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        adx      = '0;
        ady      = '0;
        err_n    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x1_d    = x1;
                    y1_d    = y1;
                    x2_d    = x2;
                    y2_d    = y2;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                sx_neg_d = !(x1_q < x2_q);
                sy_neg_d = !(y1_q < y2_q);
                if (x1_q < x2_q) adx = {2'b00, x2_q - x1_q};
                else             adx = {2'b00, x1_q - x2_q};
                if (y1_q < y2_q) ady = {2'b00, y2_q - y1_q};
                else             ady = {2'b00, y1_q - y2_q};
                dx_d    = adx;
                dy_d    = -ady;
                err_d   = adx - ady;
                cur_x_d = x1_q;
                cur_y_d = y1_q;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (pix_ready) begin
                    if (at_end) begin
                        state_d = S_FIN;
                    end else begin
                        if (step_x) begin
                            err_n   = err_n + dy_q;
                            cur_x_d = sx_neg_q ? cur_x_q - COORD_W'(1)
                                               : cur_x_q + COORD_W'(1);
                        end
                        if (step_y) begin
                            err_n   = err_n + dx_q;
                            cur_y_d = sy_neg_q ? cur_y_q - COORD_W'(1)
                                               : cur_y_q + COORD_W'(1);
                        end
                        err_d = err_n;
                    end
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x2_q     <= x2_d;
            y2_q     <= y2_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    // an abort landing in the final cycle suppresses the done pulse
    assign busy      = (state_q != S_IDLE);
    assign pix_valid = (state_q == S_DRAW);
    assign done      = (state_q == S_FIN) && !abort;
    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Directed bench for line_draw_ctrl: octant stepping, back-pressure,
// abort and asynchronous reset.
module tb_line_draw_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start, abort, pix_ready;
    logic [15:0] x1, y1, x2, y2;
    logic        busy, pix_valid, done;
    logic [15:0] pix_x, pix_y;

    int checks = 0;
    int errors = 0;

    line_draw_ctrl #(.COORD_W(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .abort     (abort),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .done      (done)
    );

    always #5 clk = ~clk;

    int lx1[4] = '{0, 5, 0, 7};
    int ly1[4] = '{0, 5, 0, 9};
    int lx2[4] = '{3, 2, 2, 7};
    int ly2[4] = '{0, 2, 5, 9};
    int lnp[4] = '{4, 4, 6, 1};
    int ex[4][6] = '{'{0, 1, 2, 3, 0, 0},
                     '{5, 4, 3, 2, 0, 0},
                     '{0, 0, 1, 1, 2, 2},
                     '{7, 0, 0, 0, 0, 0}};
    int ey[4][6] = '{'{0, 0, 0, 0, 0, 0},
                     '{5, 4, 3, 2, 0, 0},
                     '{0, 1, 2, 3, 4, 5},
                     '{9, 0, 0, 0, 0, 0}};

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, pix_valid, done, pix_x, pix_y} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %b %0d %0d want 0", busy, pix_valid, done, pix_x, pix_y);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, pix_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got %b%b%b want 000", busy, pix_valid, done);
        end
    endtask

    task automatic test_lines();
        pix_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            x1 = 16'(lx1[t]); y1 = 16'(ly1[t]);
            x2 = 16'(lx2[t]); y2 = 16'(ly2[t]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({busy, pix_valid} !== 2'b10) begin
                errors++;
                $display("FAIL line%0d_setup got busy=%b valid=%b want 1 0", t, busy, pix_valid);
            end
            for (int i = 0; i < lnp[t]; i++) begin
                @(negedge clk);
                checks++;
                if (pix_valid !== 1'b1 || pix_x !== 16'(ex[t][i]) || pix_y !== 16'(ey[t][i])) begin
                    errors++;
                    $display("FAIL line%0d_pix%0d got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                             t, i, pix_valid, pix_x, pix_y, ex[t][i], ey[t][i]);
                end
            end
            @(negedge clk);
            checks++;
            if ({done, pix_valid} !== 2'b10) begin
                errors++;
                $display("FAIL line%0d_done got done=%b valid=%b want 1 0", t, done, pix_valid);
            end
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL line%0d_idle got done=%b busy=%b want 0 0", t, done, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int c = 0;
        @(negedge clk);
        x1 = 0; y1 = 0; x2 = 3; y2 = 0;
        start = 1'b1;
        pix_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (idx < 4 && c < 40) begin
            @(negedge clk);
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== 16'(idx) || pix_y !== 16'd0) begin
                errors++;
                $display("FAIL bp_pix%0d_c%0d got v=%b (%0d,%0d) want v=1 (%0d,0)",
                         idx, c, pix_valid, pix_x, pix_y, idx);
            end
            pix_ready = (c % 3 == 0);
            if (c == 2) begin
                start = 1'b1;
                x1 = 9; y1 = 9; x2 = 12; y2 = 12;
            end else begin
                start = 1'b0;
            end
            if (pix_ready) idx++;
            c++;
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL bp_timeout got %0d pixels want 4", idx);
        end
        @(negedge clk);
        start = 1'b0;
        pix_ready = 1'b1;
        checks++;
        if ({done, pix_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_done got done=%b valid=%b want 1 0", done, pix_valid);
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL bp_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_abort();
        pix_ready = 1'b1;
        @(negedge clk);
        x1 = 0; y1 = 0; x2 = 10; y2 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== 16'(i) || pix_y !== 16'd0) begin
                errors++;
                $display("FAIL abort_pix%0d got v=%b (%0d,%0d) want v=1 (%0d,0)",
                         i, pix_valid, pix_x, pix_y, i);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({pix_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_drop got v=%b busy=%b done=%b want 000", pix_valid, busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone got done=%b want 0", done);
        end
        x1 = 4; y1 = 6; x2 = 4; y2 = 6;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart got busy=%b want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== 16'd4 || pix_y !== 16'd6) begin
            errors++;
            $display("FAIL abort_newpix got v=%b (%0d,%0d) want v=1 (4,6)", pix_valid, pix_x, pix_y);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_newdone got done=%b want 1", done);
        end
    endtask

    task automatic test_reset_midline();
        pix_ready = 1'b1;
        @(negedge clk);
        x1 = 0; y1 = 0; x2 = 10; y2 = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== 16'd1) begin
            errors++;
            $display("FAIL rst_pre got v=%b x=%0d want v=1 x=1", pix_valid, pix_x);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({busy, pix_valid, done, pix_x, pix_y} !== 35'd0) begin
            errors++;
            $display("FAIL rst_async got %b %b %b %0d %0d want 0", busy, pix_valid, done, pix_x, pix_y);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, pix_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_idle got busy=%b v=%b want 0 0", busy, pix_valid);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pix_ready = 1'b0;
        x1 = 0; y1 = 0; x2 = 0; y2 = 0;
        test_reset();
        test_lines();
        test_backpressure();
        test_abort();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
